frame_buffer_pipe: RTL and testbench

Parametrised, pipelined successor to the Hack screen frame buffer. Holds a 1-bit-per-pixel image of FB_W x FB_H pixels, packed WORD_W pixels per word. Maps VGA raster coordinates to RAM reads and emits a colour per pixel with a fixed, documented latency. Sits between the Hack CPU screen-memory write path and the VGA timing/DAC. Adds border/overlay compositing and optional double buffering.

---
 rtl/frame_buffer_pipe.sv | 185 ++++++++++++++++++
 tb/tb_frame_buffer_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pipe.sv
// frame_buffer_pipe: 1-bit-per-pixel framebuffer with a 3-stage VGA read pipeline.
// The CPU writes whole pixel words. The raster side maps (vga_h, vga_v) to a word
// address and a bit index, reads the RAM and composites framebuffer, overlay and
// border colours. pixel_out follows the coordinates by exactly 3 clocks.
// Optional build macro: FB_DOUBLE_BUFFER_EN enables two RAM pages. The CPU writes
// the hidden page, and a swap takes effect when the raster reaches (0,0).
module frame_buffer_pipe #(
   parameter int                 FB_W         = 512,
   parameter int                 FB_H         = 256,
   parameter int                 WORD_W       = 16,
   parameter int                 ADDR_W       = 13,
   parameter int                 H_OFFSET     = 144,
   parameter int                 V_OFFSET     = 112,
   parameter int                 COLOR_W      = 3,
   parameter logic [COLOR_W-1:0] FG_COLOR     = 3'b111,
   parameter logic [COLOR_W-1:0] BG_COLOR     = 3'b000,
   parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b001
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  write_address,
   input  logic [WORD_W-1:0]  data_in,
   input  logic               load,
   input  logic [10:0]        vga_h,
   input  logic [10:0]        vga_v,
   input  logic               overlay_on,
   input  logic [COLOR_W-1:0] overlay_pixel,
   input  logic               swap_req,
   output logic [COLOR_W-1:0] pixel_out,
   output logic               in_window,
   output logic               swap_done
);

   localparam int WB    = $clog2(WORD_W);
   localparam int HB    = $clog2(FB_W);
   localparam int LIN_W = ADDR_W + WB;
   localparam int VB    = LIN_W - HB;
`ifdef FB_DOUBLE_BUFFER_EN
   localparam int PB    = 1;
`else
   localparam int PB    = 0;
`endif
   localparam int DEPTH = 2 ** (ADDR_W + PB);

   // Composite priority: the window wins, then the overlay, then the border.
   function automatic logic [COLOR_W-1:0] composite(input logic               win,
                                                    input logic               pix,
                                                    input logic               ovl_on,
                                                    input logic [COLOR_W-1:0] ovl_pix);
      if (win)
         return pix ? FG_COLOR : BG_COLOR;
      else if (ovl_on)
         return ovl_pix;
      else
         return BORDER_COLOR;
   endfunction

   logic [WORD_W-1:0]       mem [DEPTH];

   logic [10:0]             hrel_c;
   logic [10:0]             vrel_c;
   logic                    win_c;
   logic [LIN_W-1:0]        lin_c;

   logic                    vld_p0;
   logic [ADDR_W-1:0]       addr_p0;
   logic [WB-1:0]           bit_p0;
   logic                    win_p0;
   logic                    ovl_on_p0;
   logic [COLOR_W-1:0]      ovl_pix_p0;

   logic                    vld_p1;
   logic [WORD_W-1:0]       rdata_p1;
   logic [WB-1:0]           bit_p1;
   logic                    win_p1;
   logic                    ovl_on_p1;
   logic [COLOR_W-1:0]      ovl_pix_p1;

   logic [ADDR_W+PB-1:0]    rd_addr;
   logic [ADDR_W+PB-1:0]    wr_addr;

   // Subtract in 11 bits; coordinates left of or above the window wrap to large
   // unsigned values and fail the compare. FB_W is a power of two, so the linear
   // pixel index is a plain concatenation of row and column.
   assign hrel_c = vga_h - 11'(H_OFFSET);
   assign vrel_c = vga_v - 11'(V_OFFSET);
   assign win_c  = (hrel_c < 11'(FB_W)) && (vrel_c < 11'(FB_H));
   assign lin_c  = {vrel_c[VB-1:0], hrel_c[HB-1:0]};

`ifdef FB_DOUBLE_BUFFER_EN
   logic display_page;
   logic swap_pend;
   logic origin_p0;
   logic take_swap;

   assign take_swap = origin_p0 & swap_pend;
   assign rd_addr   = {display_page, addr_p0};
   assign wr_addr   = {~display_page, write_address};

   // Flag when the S1 sample holds the raster origin, the only point a swap may happen
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         origin_p0 <= 1'b0;
      else
         origin_p0 <= (vga_h == 11'd0) && (vga_v == 11'd0);
   end

   // Merge swap requests into one pending flag and flip the page at the origin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display_page <= 1'b0;
         swap_pend    <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         swap_done <= take_swap;
         swap_pend <= (swap_pend & ~take_swap) | swap_req;
         if (take_swap)
            display_page <= ~display_page;
      end
   end
`else
   logic unused_swap_req;

   assign unused_swap_req = swap_req;
   assign swap_done       = 1'b0;
   assign rd_addr         = addr_p0;
   assign wr_addr         = write_address;
`endif

   // CPU write port; the RAM contents survive reset
   always_ff @(posedge clk) begin
      if (load)
         mem[wr_addr] <= data_in;
   end

   // ---- S1: address, bit index, window flag and overlay sideband ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0     <= 1'b0;
         addr_p0    <= '0;
         bit_p0     <= '0;
         win_p0     <= 1'b0;
         ovl_on_p0  <= 1'b0;
         ovl_pix_p0 <= '0;
      end else begin
         vld_p0     <= 1'b1;
         addr_p0    <= lin_c[LIN_W-1:WB];
         bit_p0     <= lin_c[WB-1:0];
         win_p0     <= win_c;
         ovl_on_p0  <= overlay_on;
         ovl_pix_p0 <= overlay_pixel;
      end
   end

   // ---- S2: synchronous RAM read (old data on a same-edge write), sidebands delayed ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         rdata_p1   <= '0;
         bit_p1     <= '0;
         win_p1     <= 1'b0;
         ovl_on_p1  <= 1'b0;
         ovl_pix_p1 <= '0;
      end else begin
         vld_p1     <= vld_p0;
         rdata_p1   <= mem[rd_addr];
         bit_p1     <= bit_p0;
         win_p1     <= win_p0;
         ovl_on_p1  <= ovl_on_p0;
         ovl_pix_p1 <= ovl_pix_p0;
      end
   end

   // ---- S3: bit select and composite; hold 0 until the pipeline has refilled ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_out <= '0;
         in_window <= 1'b0;
      end else begin
         pixel_out <= vld_p1 ? composite(win_p1, rdata_p1[bit_p1], ovl_on_p1, ovl_pix_p1) : '0;
         in_window <= vld_p1 & win_p1;
      end
   end

endmodule

// File: tb/tb_frame_buffer_pipe.sv
// Testbench for frame_buffer_pipe. A behavioural model computes the composite
// colour from raster arithmetic and a word-addressed memory image. The model output
// is compared on every cycle, and directed vectors carry hand-computed colours.
`timescale 1ns/1ps
module tb_frame_buffer_pipe;

   localparam int         FB_W   = 512;
   localparam int         FB_H   = 256;
   localparam int         WORD_W = 16;
   localparam int         ADDR_W = 13;
   localparam int         HO     = 144;
   localparam int         VO     = 112;
   localparam logic [2:0] FG     = 3'b111;
   localparam logic [2:0] BG     = 3'b000;
   localparam logic [2:0] BORDER = 3'b001;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] write_address;
   logic [WORD_W-1:0] data_in;
   logic              load;
   logic [10:0]       vga_h;
   logic [10:0]       vga_v;
   logic              overlay_on;
   logic [2:0]        overlay_pixel;
   logic              swap_req;
   logic [2:0]        pixel_out;
   logic              in_window;
   logic              swap_done;

   always #5 clk = ~clk;

   frame_buffer_pipe dut (
      .clk           (clk),
      .reset         (reset),
      .write_address (write_address),
      .data_in       (data_in),
      .load          (load),
      .vga_h         (vga_h),
      .vga_v         (vga_v),
      .overlay_on    (overlay_on),
      .overlay_pixel (overlay_pixel),
      .swap_req      (swap_req),
      .pixel_out     (pixel_out),
      .in_window     (in_window),
      .swap_done     (swap_done)
   );

   int n_cmp    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   typedef struct {
      int         tgt;
      logic [2:0] pix;
      bit         win;
      bit         done;
      string      nm;
   } lit_t;
   lit_t lit_q[$];

   function automatic void pushlit(input string nm, input int tgt, input logic [2:0] p,
                                   input bit w, input bit d);
      lit_t l;
      l.tgt  = tgt;
      l.pix  = p;
      l.win  = w;
      l.done = d;
      l.nm   = nm;
      lit_q.push_back(l);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   logic [WORD_W-1:0] mem_m [int];
   bit                s1_v, s1_win, s1_org, s1_ovl;
   int                s1_key, s1_bit;
   logic [2:0]        s1_op;
   bit                rd_v, rd_win, rd_ovl, rd_known;
   int                rd_bit;
   logic [2:0]        rd_op;
   logic [WORD_W-1:0] rd_word;
   bit                pg, pend, old_pg;
   logic [2:0]        exp_pix;
   bit                exp_win, exp_done, exp_known;
   int                mh, mv, rkey, wkey;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v = 0; s1_org = 0; rd_v = 0; pg = 0; pend = 0;
         exp_pix = 3'b000; exp_win = 0; exp_done = 0; exp_known = 1;
      end else begin
         // colour for the pixel whose word was fetched on the previous edge
         exp_known = 1;
         if (!rd_v) begin
            exp_win = 0;
            exp_pix = 3'b000;
         end else if (rd_win) begin
            exp_win   = 1;
            exp_known = rd_known;
            exp_pix   = rd_word[rd_bit] ? FG : BG;
         end else begin
            exp_win = 0;
            exp_pix = rd_ovl ? rd_op : BORDER;
         end
         // fetch the word for the coordinates sampled on the previous edge
         rkey     = s1_key + (pg ? (1 << ADDR_W) : 0);
         rd_v     = s1_v;
         rd_win   = s1_win;
         rd_ovl   = s1_ovl;
         rd_op    = s1_op;
         rd_bit   = s1_bit;
         rd_known = mem_m.exists(rkey);
         rd_word  = rd_known ? mem_m[rkey] : '0;
         // page swap and write
         old_pg = pg;
`ifdef FB_DOUBLE_BUFFER_EN
         exp_done = s1_v && s1_org && pend;
         if (exp_done) pg = ~pg;
         pend = (pend && !exp_done) || (swap_req === 1'b1);
         wkey = int'(write_address) + (!old_pg ? (1 << ADDR_W) : 0);
`else
         exp_done = 0;
         wkey = int'(write_address) + (old_pg ? (1 << ADDR_W) : 0);
`endif
         if (load === 1'b1) mem_m[wkey] = data_in;
         // sample the new coordinates
         mh     = int'(vga_h);
         mv     = int'(vga_v);
         s1_v   = 1;
         s1_win = (mh >= HO) && (mh <= HO + FB_W - 1) && (mv >= VO) && (mv <= VO + FB_H - 1);
         s1_key = s1_win ? ((mv - VO) * FB_W + (mh - HO)) / WORD_W : 0;
         s1_bit = s1_win ? (mh - HO) % WORD_W : 0;
         s1_org = (mh == 0) && (mv == 0);
         s1_ovl = (overlay_on === 1'b1);
         s1_op  = overlay_pixel;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      lit_t l;
      chk("cyc_win", 32'(in_window), 32'(exp_win));
      chk("cyc_done", 32'(swap_done), 32'(exp_done));
      if (exp_known) chk("cyc_pix", 32'(pixel_out), 32'(exp_pix));
      if (swap_done === 1'b1) done_cnt++;
      while (lit_q.size() > 0 && lit_q[0].tgt <= cyc) begin
         l = lit_q.pop_front();
         if (l.tgt != cyc) begin
            chk({l.nm, "_missed"}, 32'(cyc), 32'(l.tgt));
         end else begin
            chk(l.nm, 32'(pixel_out), 32'(l.pix));
            chk({l.nm, "_win"}, 32'(in_window), 32'(l.win));
            chk({l.nm, "_done"}, 32'(swap_done), 32'(l.done));
            chk({l.nm, "_model"}, 32'(exp_pix), 32'(l.pix));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic px(input int h, input int v);
      vga_h    = 11'(h);
      vga_v    = 11'(v);
      load     = 1'b0;
      swap_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic pxe(input string nm, input int h, input int v, input logic [2:0] p, input bit w);
      pushlit(nm, cyc + 3, p, w, 1'b0);
      px(h, v);
   endtask

   task automatic wr(input int a, input logic [WORD_W-1:0] d);
      vga_h         = 11'd1;
      vga_v         = 11'd1;
      write_address = ADDR_W'(a);
      data_in       = d;
      load          = 1'b1;
      swap_req      = 1'b0;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic req();
      vga_h    = 11'd1;
      vga_v    = 11'd1;
      load     = 1'b0;
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset = 1'b1; load = 1'b0; swap_req = 1'b0; overlay_on = 1'b0; overlay_pixel = 3'b000;
      vga_h = 11'd1; vga_v = 11'd1; write_address = '0; data_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_pix", 32'(pixel_out), 32'd0);
      chk("rst_win", 32'(in_window), 32'd0);
      chk("rst_done", 32'(swap_done), 32'd0);
      reset = 1'b0;

`ifndef FB_DOUBLE_BUFFER_EN
      wr(0, 16'h0001);
      pxe("t1_fg", 144, 112, FG, 1'b1);
      pxe("t1_bg", 145, 112, BG, 1'b1);
      wr(8191, 16'h8000);
      pxe("t2_last", 655, 367, FG, 1'b1);
      pxe("t2_right", 656, 367, BORDER, 1'b0);
      pxe("t2_left", 143, 112, BORDER, 1'b0);
      wr(2819, 16'h0000);
      overlay_on = 1'b1; overlay_pixel = 3'b100;
      pxe("t3_ovl", 10, 10, 3'b100, 1'b0);
      pxe("t3_inwin", 200, 200, BG, 1'b1);
      overlay_on = 1'b0; overlay_pixel = 3'b000;
      wr(5, 16'h0000);
      pxe("t4_old", 224, 112, BG, 1'b1);
      // this write lands on the same edge that fetches word 5 for the pixel above
      vga_h = 11'd1; vga_v = 11'd1; write_address = ADDR_W'(5); data_in = 16'h0001; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      pxe("t4_new", 224, 112, FG, 1'b1);
`endif

      // asynchronous reset while streaming, then refill
      repeat (4) px(10, 10);
      chk("pre_rst_pix", 32'(pixel_out), 32'(BORDER));
      #2 reset = 1'b1;
      #1 chk("async_rst_pix", 32'(pixel_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      k = cyc;
      pushlit("rel_hold", k + 2, 3'b000, 1'b0, 1'b0);
      pushlit("rel_first", k + 3, BORDER, 1'b0, 1'b0);
      repeat (5) px(10, 10);

`ifdef FB_DOUBLE_BUFFER_EN
      wr(0, 16'h0000);
      req();
      px(5, 5);
      pushlit("swap0_done", cyc + 2, BORDER, 1'b0, 1'b1);
      px(0, 0);
      px(5, 5);
      wr(0, 16'hFFFF);
      pxe("db_before", 144, 112, BG, 1'b1);
      done_cnt = 0;
      req();
      px(300, 200);
      req();
      px(5, 5);
      pushlit("db_done", cyc + 2, BORDER, 1'b0, 1'b1);
      pxe("db_org", 0, 0, BORDER, 1'b0);
      pxe("db_after", 144, 112, FG, 1'b1);
      repeat (4) px(1, 1);
      chk("db_one_pulse", 32'(done_cnt), 32'd1);
`endif

      repeat (5) px(1, 1);
      chk("lit_pending", 32'(lit_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
